// File: rtl/pc_sequencer_pkg.sv
// Constants shared by the PC sequencer and the control FSM that drives it.
package pc_pkg;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_RETURN = 2'b11;

  function automatic logic sel_is_call(input logic [1:0] sel);
    return (sel == SEL_BRANCH) || (sel == SEL_JUMP);
  endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // ptr_q is the next free slot; once full it points at the oldest entry.
  assign top_o   = mem_q[ptr_q - PTR_W'(1)];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) count_d = count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: data words are not reset; the zeroed count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[ptr_q] <= data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: next-PC mux, PC register, sticky RAS error flag and return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH  = 16,
  parameter int                  PC_STEP   = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_en,
  input  logic [1:0]          sel,
  input  logic [PC_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                push,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_err
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] ras_top;
  logic                err_q, err_d;
  logic                ras_push, ras_pop;

  assign pc_seq  = pc_q + PC_WIDTH'(PC_STEP);
  assign pc      = pc_q;
  assign ras_err = err_q;

  always_comb begin
    pc_d     = pc_q;
    err_d    = err_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (pc_en) begin
      case (sel)
        SEL_SEQ:    pc_d = pc_seq;
        SEL_BRANCH: pc_d = pc_q + offset;
        SEL_JUMP:   pc_d = target;
        SEL_RETURN: begin
          // Underflow falls through to the sequential address and flags the error.
          if (ras_empty) begin
            pc_d  = pc_seq;
            err_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
      endcase
      if (push) begin
        if (sel_is_call(sel)) ras_push = 1'b1;
        else                  err_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  ras_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_seq),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table plus hand sequences, expectations queued and checked after each edge.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en;
  logic [1:0]  sel;
  logic [15:0] offset;
  logic [15:0] target;
  logic        push;
  logic [15:0] pc;
  logic        ras_empty, ras_full, ras_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  sel;
    logic [15:0] offset;
    logic [15:0] target;
    logic        push;
    logic [15:0] exp_pc;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        err;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  pc_sequencer #(
    .PC_WIDTH  (16),
    .PC_STEP   (1),
    .RESET_PC  (16'h0040),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_en     (pc_en),
    .sel       (sel),
    .offset    (offset),
    .target    (target),
    .push      (push),
    .pc        (pc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic en, input logic [1:0] s,
                              input logic [15:0] off, input logic [15:0] tgt, input logic p,
                              input logic [15:0] epc, input logic ee, input logic ef,
                              input logic eerr, input string name);
    vec_t v;
    v.rst = rst; v.en = en; v.sel = s; v.offset = off; v.target = tgt; v.push = p;
    v.exp_pc = epc; v.exp_empty = ee; v.exp_full = ef; v.exp_err = eerr; v.name = name;
    return v;
  endfunction

  // Drive one cycle at the falling edge, queue its expectation, compare after the rising edge.
  task automatic step(input vec_t v);
    exp_t e, got;
    @(negedge clk);
    reset = v.rst; pc_en = v.en; sel = v.sel; offset = v.offset; target = v.target; push = v.push;
    e.pc = v.exp_pc; e.empty = v.exp_empty; e.full = v.exp_full; e.err = v.exp_err; e.name = v.name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      got = exp_q.pop_front();
      check({got.name, ".pc"},    32'(pc),        32'(got.pc));
      check({got.name, ".empty"}, 32'(ras_empty), 32'(got.empty));
      check({got.name, ".full"},  32'(ras_full),  32'(got.full));
      check({got.name, ".err"},   32'(ras_err),   32'(got.err));
    end
  endtask

  initial begin
    reset = 1'b1; pc_en = 1'b0; sel = SEL_SEQ; offset = '0; target = '0; push = 1'b0;

    // Reset, hold, sequential/branch/jump, wrap, call/return, underflow, illegal push.
    vecs.push_back(mk(1, 1, SEL_JUMP,   16'h0000, 16'h7777, 1, 16'h0040, 1, 0, 0, "rst0"));
    vecs.push_back(mk(1, 0, SEL_SEQ,    16'h0000, 16'h0000, 0, 16'h0040, 1, 0, 0, "rst1"));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 2'(i), 16'h0123, 16'h4567, 1, 16'h0040, 1, 0, 0, $sformatf("hold%0d", i)));
    vecs.push_back(mk(0, 1, SEL_SEQ,    16'h0000, 16'h0000, 0, 16'h0041, 1, 0, 0, "seq"));
    vecs.push_back(mk(0, 1, SEL_BRANCH, 16'hFFFE, 16'h0000, 0, 16'h003F, 1, 0, 0, "branch_back"));
    vecs.push_back(mk(0, 1, SEL_JUMP,   16'h0000, 16'h1234, 0, 16'h1234, 1, 0, 0, "jump"));
    vecs.push_back(mk(0, 1, SEL_JUMP,   16'h0000, 16'hFFFF, 0, 16'hFFFF, 1, 0, 0, "jump_top"));
    vecs.push_back(mk(0, 1, SEL_SEQ,    16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, "seq_wrap"));
    vecs.push_back(mk(0, 1, SEL_BRANCH, 16'h0005, 16'h0000, 0, 16'h0005, 1, 0, 0, "branch_fwd"));
    vecs.push_back(mk(0, 1, SEL_JUMP,   16'h0000, 16'h0100, 0, 16'h0100, 1, 0, 0, "jump_0100"));
    vecs.push_back(mk(0, 1, SEL_JUMP,   16'h0000, 16'h0200, 1, 16'h0200, 0, 0, 0, "call"));
    vecs.push_back(mk(0, 0, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h0200, 0, 0, 0, "ret_hold"));
    vecs.push_back(mk(0, 1, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h0101, 1, 0, 0, "ret"));
    vecs.push_back(mk(0, 1, SEL_JUMP,   16'h0000, 16'h0300, 0, 16'h0300, 1, 0, 0, "jump_0300"));
    vecs.push_back(mk(0, 1, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h0301, 1, 0, 1, "ret_empty"));
    vecs.push_back(mk(0, 1, SEL_SEQ,    16'h0000, 16'h0000, 0, 16'h0302, 1, 0, 1, "err_sticky"));
    vecs.push_back(mk(1, 0, SEL_SEQ,    16'h0000, 16'h0000, 0, 16'h0040, 1, 0, 0, "rst_clr"));
    vecs.push_back(mk(0, 1, SEL_SEQ,    16'h0000, 16'h0000, 1, 16'h0041, 1, 0, 1, "push_seq"));
    vecs.push_back(mk(1, 0, SEL_SEQ,    16'h0000, 16'h0000, 0, 16'h0040, 1, 0, 0, "rst_clr2"));

    foreach (vecs[i]) step(vecs[i]);

    // Overflow: five calls into a four-deep stack, then unwind.
    step(mk(0, 1, SEL_JUMP,   16'h0000, 16'h1000, 1, 16'h1000, 0, 0, 0, "ovf_push1"));
    step(mk(0, 1, SEL_JUMP,   16'h0000, 16'h2000, 1, 16'h2000, 0, 0, 0, "ovf_push2"));
    step(mk(0, 1, SEL_JUMP,   16'h0000, 16'h3000, 1, 16'h3000, 0, 0, 0, "ovf_push3"));
    step(mk(0, 1, SEL_JUMP,   16'h0000, 16'h4000, 1, 16'h4000, 0, 1, 0, "ovf_push4"));
    step(mk(0, 1, SEL_BRANCH, 16'h0010, 16'h0000, 1, 16'h4010, 0, 1, 0, "ovf_push5"));
    step(mk(0, 1, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h4001, 0, 0, 0, "ovf_ret5"));
    step(mk(0, 1, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h3001, 0, 0, 0, "ovf_ret4"));
    step(mk(0, 1, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h2001, 0, 0, 0, "ovf_ret3"));
    step(mk(0, 1, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h1001, 1, 0, 0, "ovf_ret2"));
    step(mk(0, 1, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h1002, 1, 0, 1, "ovf_underflow"));

    // Reset in the same cycle as a call must win and leave the stack empty.
    step(mk(1, 0, SEL_SEQ,    16'h0000, 16'h0000, 0, 16'h0040, 1, 0, 0, "mid_rst0"));
    step(mk(0, 1, SEL_JUMP,   16'h0000, 16'h0500, 1, 16'h0500, 0, 0, 0, "mid_call"));
    step(mk(1, 1, SEL_JUMP,   16'h0000, 16'h0200, 1, 16'h0040, 1, 0, 0, "mid_rst_call"));
    step(mk(0, 0, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h0040, 1, 0, 0, "mid_hold_ret"));
    step(mk(0, 1, SEL_RETURN, 16'h0000, 16'h0000, 0, 16'h0041, 1, 0, 1, "mid_ret_empty"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
